operand_fetch: RTL and testbench

//  Initiator side of the 2R/1W register-file interface. Issues read addresses, aligns the 1-cycle registered read data,
//  and tracks pending writes with a scoreboard. Fixes stale same-edge read-vs-write data by bypass, then hands operands
//  to execute with a valid/ready handshake. Sits between decode and execute; wb_* also drives the regfile write port at top level.

---
 rtl/opf_pkg.sv | 27 ++
 rtl/opf_scoreboard.sv | 42 ++++
 rtl/operand_fetch.sv | 160 ++++++++++++++++
 tb/tb_operand_fetch.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opf_pkg.sv
// Shared widths and payload types for the operand-fetch stage.
package opf_pkg;

   localparam int unsigned DATA_W = 36;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned TAG_W  = 8;
   localparam int unsigned NREGS  = 2 ** ADDR_W;

   // Instruction as presented by decode.
   typedef struct packed {
      logic [ADDR_W-1:0] rs1;
      logic [ADDR_W-1:0] rs2;
      logic [ADDR_W-1:0] rd;
      logic              rd_we;
      logic [TAG_W-1:0]  tag;
   } opf_req_t;

   // Operand bundle handed to execute.
   typedef struct packed {
      logic [DATA_W-1:0] op1;
      logic [DATA_W-1:0] op2;
      logic [ADDR_W-1:0] rd;
      logic              rd_we;
      logic [TAG_W-1:0]  tag;
   } opf_out_t;

endpackage

// File: rtl/opf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by an issuing writer,
// cleared by writeback (set wins on the same address). Register 0 is never pending.
// Ports: clk/rst_n (sync, active low); set_en_i/set_addr_i; clr_en_i/clr_addr_i;
//        rs1_i/rs2_i/rd_i lookups; raw1_hit_o/raw2_hit_o/waw_hit_o combinational hits.
module opf_scoreboard
   import opf_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              set_en_i,
   input  logic [ADDR_W-1:0] set_addr_i,
   input  logic              clr_en_i,
   input  logic [ADDR_W-1:0] clr_addr_i,
   input  logic [ADDR_W-1:0] rs1_i,
   input  logic [ADDR_W-1:0] rs2_i,
   input  logic [ADDR_W-1:0] rd_i,
   output logic              raw1_hit_o,
   output logic              raw2_hit_o,
   output logic              waw_hit_o
);

   logic [NREGS-1:0] pend_q;
   logic [NREGS-1:0] pend_d;

   // Clear first so a same-cycle set of the same address wins.
   always_comb begin
      pend_d = pend_q;
      if (clr_en_i) pend_d[clr_addr_i] = 1'b0;
      if (set_en_i) pend_d[set_addr_i] = 1'b1;
      pend_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) pend_q <= '0;
      else        pend_q <= pend_d;
   end

   assign raw1_hit_o = (rs1_i != '0) & pend_q[rs1_i];
   assign raw2_hit_o = (rs2_i != '0) & pend_q[rs2_i];
   assign waw_hit_o  = (rd_i  != '0) & pend_q[rd_i];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: drives regfile read addresses, aligns the 1-cycle read data,
// stalls on pending writes (RAW/WAW) and hands operands to execute.
// Ports: in_* decode handshake + fields; rf_rd*_addr/rf_rd*_data regfile reads;
//        wb_* writeback snoop; out_* execute handshake + operands.
// Build option: OPFETCH_BYPASS_EN lets a source being written back this cycle issue without stall.
module operand_fetch
   import opf_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_rs1,
   input  logic [ADDR_W-1:0] in_rs2,
   input  logic [ADDR_W-1:0] in_rd,
   input  logic              in_rd_we,
   input  logic [TAG_W-1:0]  in_tag,
   output logic [ADDR_W-1:0] rf_rd1_addr,
   output logic [ADDR_W-1:0] rf_rd2_addr,
   input  logic [DATA_W-1:0] rf_rd1_data,
   input  logic [DATA_W-1:0] rf_rd2_data,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_op1,
   output logic [DATA_W-1:0] out_op2,
   output logic [ADDR_W-1:0] out_rd,
   output logic              out_rd_we,
   output logic [TAG_W-1:0]  out_tag
);

   opf_req_t          req;
   opf_req_t          s1_q, s1_d;
   logic              s1_valid_q, s1_valid_d;
   logic              first_q, first_d;
   logic              byp1_hit_q, byp1_hit_d;
   logic              byp2_hit_q, byp2_hit_d;
   logic [DATA_W-1:0] byp_data_q, byp_data_d;
   logic [DATA_W-1:0] hold1_q, hold1_d;
   logic [DATA_W-1:0] hold2_q, hold2_d;

   logic raw1, raw2, waw;
   logic byp_ok1, byp_ok2, wb_to_rd;
   logic wb_hit1, wb_hit2;
   logic hazard, in_fire, out_fire;
   logic [DATA_W-1:0] op1_c, op2_c;
   opf_out_t out_c;

   assign req = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, rd_we: in_rd_we, tag: in_tag};

   assign rf_rd1_addr = in_rs1;
   assign rf_rd2_addr = in_rs2;

   opf_scoreboard u_sb (
      .clk        (clk),
      .rst_n      (rst_n),
      .set_en_i   (in_fire & in_rd_we & (in_rd != '0)),
      .set_addr_i (in_rd),
      .clr_en_i   (wb_en),
      .clr_addr_i (wb_addr),
      .rs1_i      (in_rs1),
      .rs2_i      (in_rs2),
      .rd_i       (in_rd),
      .raw1_hit_o (raw1),
      .raw2_hit_o (raw2),
      .waw_hit_o  (waw)
   );

   // Writeback landing on a source this edge: regfile returns the old value, so capture wb_data.
   assign wb_hit1 = wb_en & (wb_addr == in_rs1) & (in_rs1 != '0);
   assign wb_hit2 = wb_en & (wb_addr == in_rs2) & (in_rs2 != '0);

`ifdef OPFETCH_BYPASS_EN
   assign byp_ok1 = wb_en & (wb_addr == in_rs1);
   assign byp_ok2 = wb_en & (wb_addr == in_rs2);
`else
   assign byp_ok1 = 1'b0;
   assign byp_ok2 = 1'b0;
`endif

   assign wb_to_rd = wb_en & (wb_addr == in_rd);
   assign hazard   = (raw1 & ~byp_ok1) | (raw2 & ~byp_ok2) | (in_rd_we & waw & ~wb_to_rd);
   assign in_ready = (~s1_valid_q | out_ready) & ~hazard;
   assign in_fire  = in_valid & in_ready;
   assign out_fire = s1_valid_q & out_ready;

   // First S1 cycle takes the aligned regfile/bypass data; later cycles replay the hold regs.
   always_comb begin
      op1_c = hold1_q;
      op2_c = hold2_q;
      if (first_q) begin
         if (s1_q.rs1 == '0)  op1_c = '0;
         else if (byp1_hit_q) op1_c = byp_data_q;
         else                 op1_c = rf_rd1_data;
         if (s1_q.rs2 == '0)  op2_c = '0;
         else if (byp2_hit_q) op2_c = byp_data_q;
         else                 op2_c = rf_rd2_data;
      end
   end

   // S1 slot next-state.
   always_comb begin
      s1_d       = s1_q;
      s1_valid_d = s1_valid_q;
      first_d    = 1'b0;
      byp1_hit_d = byp1_hit_q;
      byp2_hit_d = byp2_hit_q;
      byp_data_d = byp_data_q;
      hold1_d    = hold1_q;
      hold2_d    = hold2_q;
      if (first_q && !out_ready) begin
         hold1_d = op1_c;
         hold2_d = op2_c;
      end
      if (in_fire) begin
         s1_d       = req;
         s1_valid_d = 1'b1;
         first_d    = 1'b1;
         byp1_hit_d = wb_hit1;
         byp2_hit_d = wb_hit2;
         byp_data_d = wb_data;
      end else if (out_fire) begin
         s1_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q       <= '0;
         s1_valid_q <= 1'b0;
         first_q    <= 1'b0;
         byp1_hit_q <= 1'b0;
         byp2_hit_q <= 1'b0;
         byp_data_q <= '0;
         hold1_q    <= '0;
         hold2_q    <= '0;
      end else begin
         s1_q       <= s1_d;
         s1_valid_q <= s1_valid_d;
         first_q    <= first_d;
         byp1_hit_q <= byp1_hit_d;
         byp2_hit_q <= byp2_hit_d;
         byp_data_q <= byp_data_d;
         hold1_q    <= hold1_d;
         hold2_q    <= hold2_d;
      end
   end

   assign out_c = '{op1: op1_c, op2: op2_c, rd: s1_q.rd, rd_we: s1_q.rd_we, tag: s1_q.tag};

   assign out_valid = s1_valid_q;
   assign out_op1   = out_c.op1;
   assign out_op2   = out_c.op2;
   assign out_rd    = out_c.rd;
   assign out_rd_we = out_c.rd_we;
   assign out_tag   = out_c.tag;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch with a behavioural 2R/1W regfile and writeback agent.
module tb_operand_fetch;
   import opf_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid, in_ready, in_rd_we;
   logic [ADDR_W-1:0] in_rs1, in_rs2, in_rd;
   logic [TAG_W-1:0]  in_tag;
   logic [ADDR_W-1:0] rf_rd1_addr, rf_rd2_addr;
   logic [DATA_W-1:0] rf_rd1_data, rf_rd2_data;
   logic              wb_en;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              out_valid, out_ready, out_rd_we;
   logic [DATA_W-1:0] out_op1, out_op2;
   logic [ADDR_W-1:0] out_rd;
   logic [TAG_W-1:0]  out_tag;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   operand_fetch dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we), .in_tag(in_tag),
      .rf_rd1_addr(rf_rd1_addr), .rf_rd2_addr(rf_rd2_addr),
      .rf_rd1_data(rf_rd1_data), .rf_rd2_data(rf_rd2_data),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_rd_we(out_rd_we), .out_tag(out_tag)
   );

   function automatic logic [DATA_W-1:0] preload(input int i);
      if (i == 0) return '0;
      if (i == 3) return 36'h123456789;
      return {4'hC, 8'(i), 24'h00A5A5} ^ 36'(i * 7919);
   endfunction

   // Regfile model: registered read (old data on a same-edge write); reloads while in reset.
   logic [DATA_W-1:0] mem [NREGS];
   always @(posedge clk) begin
      rf_rd1_data <= mem[rf_rd1_addr];
      rf_rd2_data <= mem[rf_rd2_addr];
      if (!rst_n) begin
         for (int i = 0; i < int'(NREGS); i++) mem[i] <= preload(i);
      end else if (wb_en && wb_addr != '0) begin
         mem[wb_addr] <= wb_data;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int rs1, input int rs2, input int rd, input logic we, input int tag);
      in_valid = 1'b1;
      in_rs1   = ADDR_W'(rs1);
      in_rs2   = ADDR_W'(rs2);
      in_rd    = ADDR_W'(rd);
      in_rd_we = we;
      in_tag   = TAG_W'(tag);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
      tick(); tick();
      rst_n = 1'b1;
   endtask

   typedef struct {
      int                rs1, rs2, tag;
      logic [DATA_W-1:0] e1, e2;
   } vec_t;

   typedef struct {
      logic [DATA_W-1:0] op1, op2;
      logic [ADDR_W-1:0] rd;
      logic              rd_we;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } exp_t;

   typedef struct {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } wb_t;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t              vecs [6];
      exp_t              expq [$];
      wb_t               wbq  [$];
      exp_t              e;
      logic [DATA_W-1:0] prog_val [NREGS];
      bit                pres, wb_pop, fire, ofire;
      int                n_acc, seq;

      in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rd_we = 1'b0; in_tag = '0;
      wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
      do_reset();

      // reset state
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_op1",   64'(out_op1),   64'd0);
      check("rst_out_tag",   64'(out_tag),   64'd0);
      check("rst_out_rd",    64'(out_rd),    64'd0);

      // 1: basic read, r0 reads zero
      issue(3, 0, 0, 1'b0, 8'h01);
      #1 check("t1_in_ready", 64'(in_ready), 64'd1);
      tick(); in_valid = 1'b0;
      check("t1_out_valid", 64'(out_valid), 64'd1);
      check("t1_op1", 64'(out_op1), 64'h123456789);
      check("t1_op2", 64'(out_op2), 64'd0);
      check("t1_tag", 64'(out_tag), 64'h01);
      tick();
      check("t1_drained", 64'(out_valid), 64'd0);

      // table: back-to-back independent reads
      vecs[0] = '{rs1: 1,  rs2: 2,  tag: 8'h10, e1: preload(1),  e2: preload(2)};
      vecs[1] = '{rs1: 0,  rs2: 31, tag: 8'h11, e1: '0,          e2: preload(31)};
      vecs[2] = '{rs1: 31, rs2: 0,  tag: 8'h12, e1: preload(31), e2: '0};
      vecs[3] = '{rs1: 3,  rs2: 3,  tag: 8'h13, e1: preload(3),  e2: preload(3)};
      vecs[4] = '{rs1: 15, rs2: 16, tag: 8'h14, e1: preload(15), e2: preload(16)};
      vecs[5] = '{rs1: 30, rs2: 29, tag: 8'hFF, e1: preload(30), e2: preload(29)};
      for (int i = 0; i < 6; i++) begin
         issue(vecs[i].rs1, vecs[i].rs2, 0, 1'b0, vecs[i].tag);
         #1 check("tbl_in_ready", 64'(in_ready), 64'd1);
         tick();
         check("tbl_out_valid", 64'(out_valid), 64'd1);
         check("tbl_op1", 64'(out_op1), 64'(vecs[i].e1));
         check("tbl_op2", 64'(out_op2), 64'(vecs[i].e2));
         check("tbl_tag", 64'(out_tag), 64'(vecs[i].tag));
      end
      in_valid = 1'b0;
      tick();

      // 2: RAW stall until writeback
      issue(0, 0, 5, 1'b1, 8'h02);
      tick();
      check("t2_prod_rd", 64'(out_rd), 64'd5);
      check("t2_prod_we", 64'(out_rd_we), 64'd1);
      issue(5, 0, 0, 1'b0, 8'h03);
      #1 check("t2_stall_a", 64'(in_ready), 64'd0);
      tick();
      #1 check("t2_stall_b", 64'(in_ready), 64'd0);
      wb_en = 1'b1; wb_addr = 5'd5; wb_data = 36'hABC;
`ifdef OPFETCH_BYPASS_EN
      #1 check("t2_wb_accept", 64'(in_ready), 64'd1);
      tick(); wb_en = 1'b0; in_valid = 1'b0;
`else
      #1 check("t2_wb_stall", 64'(in_ready), 64'd0);
      tick(); wb_en = 1'b0;
      #1 check("t2_after_wb", 64'(in_ready), 64'd1);
      tick(); in_valid = 1'b0;
`endif
      check("t2_out_valid", 64'(out_valid), 64'd1);
      check("t2_op1", 64'(out_op1), 64'hABC);
      check("t2_tag", 64'(out_tag), 64'h03);
      tick();

      // 3: same-edge write to a non-pending source
      issue(0, 7, 0, 1'b0, 8'h04);
      wb_en = 1'b1; wb_addr = 5'd7; wb_data = 36'h55;
      #1 check("t3_in_ready", 64'(in_ready), 64'd1);
      tick(); in_valid = 1'b0; wb_en = 1'b0;
      check("t3_op2", 64'(out_op2), 64'h55);
      tick();

      // 4: hold under backpressure, then 1/cycle
      issue(1, 2, 0, 1'b0, 8'h44);
      out_ready = 1'b0;
      tick(); in_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         in_rs1 = ADDR_W'(6 + c); in_rs2 = ADDR_W'(20 + c);
         #1;
         check("t4_hold_valid", 64'(out_valid), 64'd1);
         check("t4_hold_op1", 64'(out_op1), 64'(preload(1)));
         check("t4_hold_op2", 64'(out_op2), 64'(preload(2)));
         check("t4_hold_tag", 64'(out_tag), 64'h44);
         tick();
      end
      out_ready = 1'b1;
      issue(10, 0, 0, 1'b0, 8'h45);
      #1 check("t4_b2b_ready_a", 64'(in_ready), 64'd1);
      tick();
      check("t4_b2b_tag_a", 64'(out_tag), 64'h45);
      check("t4_b2b_op1_a", 64'(out_op1), 64'(preload(10)));
      issue(11, 0, 0, 1'b0, 8'h46);
      #1 check("t4_b2b_ready_b", 64'(in_ready), 64'd1);
      tick(); in_valid = 1'b0;
      check("t4_b2b_tag_b", 64'(out_tag), 64'h46);
      check("t4_b2b_op1_b", 64'(out_op1), 64'(preload(11)));
      tick();
      check("t4_drained", 64'(out_valid), 64'd0);

      // 5: WAW stall, set wins over clear
      issue(0, 0, 9, 1'b1, 8'h50);
      tick();
      issue(0, 0, 9, 1'b1, 8'h51);
      #1 check("t5_waw_a", 64'(in_ready), 64'd0);
      tick();
      #1 check("t5_waw_b", 64'(in_ready), 64'd0);
      wb_en = 1'b1; wb_addr = 5'd9; wb_data = 36'h99;
      #1 check("t5_waw_wb", 64'(in_ready), 64'd1);
      tick(); wb_en = 1'b0;
      check("t5_tag", 64'(out_tag), 64'h51);
      issue(9, 0, 0, 1'b0, 8'h52);
      #1 check("t5_still_pend", 64'(in_ready), 64'd0);
      in_valid = 1'b0;
      wb_en = 1'b1; wb_addr = 5'd9; wb_data = 36'h9A;
      tick(); wb_en = 1'b0;
      tick();

      // 6: reset mid-transfer
      out_ready = 1'b0;
      issue(0, 0, 4, 1'b1, 8'h60);
      #1 check("t6_issue", 64'(in_ready), 64'd1);
      tick(); in_valid = 1'b0;
      check("t6_pre_valid", 64'(out_valid), 64'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; out_ready = 1'b1;
      check("t6_rst_valid", 64'(out_valid), 64'd0);
      check("t6_rst_tag", 64'(out_tag), 64'd0);
      issue(4, 0, 0, 1'b0, 8'h61);
      #1 check("t6_pend_clear", 64'(in_ready), 64'd1);
      tick(); in_valid = 1'b0;
      check("t6_op1", 64'(out_op1), 64'(preload(4)));
      tick();

      // random traffic against a program-order register model
      do_reset();
      for (int i = 0; i < int'(NREGS); i++) prog_val[i] = preload(i);
      pres = 1'b0; n_acc = 0; seq = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         wb_pop = 1'b0;
         wb_en  = 1'b0;
         if (wbq.size() > 0 && $urandom_range(0, 2) != 0) begin
            wb_en = 1'b1; wb_addr = wbq[0].rd; wb_data = wbq[0].data; wb_pop = 1'b1;
         end
         if (!pres) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_rs1   = ADDR_W'($urandom_range(0, 7));
            in_rs2   = ADDR_W'($urandom_range(0, 7));
            in_rd    = ADDR_W'($urandom_range(0, 7));
            in_rd_we = ($urandom_range(0, 1) != 0);
            in_tag   = TAG_W'(seq);
            pres     = in_valid;
         end
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         check("rnd_out_valid", 64'(out_valid), 64'(expq.size() != 0));
         if (expq.size() != 0) begin
            check("rnd_op1",   64'(out_op1),   64'(expq[0].op1));
            check("rnd_op2",   64'(out_op2),   64'(expq[0].op2));
            check("rnd_rd",    64'(out_rd),    64'(expq[0].rd));
            check("rnd_rd_we", 64'(out_rd_we), 64'(expq[0].rd_we));
            check("rnd_tag",   64'(out_tag),   64'(expq[0].tag));
         end
         fire  = in_valid && in_ready;
         ofire = out_valid && out_ready && (expq.size() != 0);
         if (wb_pop) void'(wbq.pop_front());
         if (ofire) begin
            e = expq.pop_front();
            if (e.rd_we && e.rd != '0) wbq.push_back('{rd: e.rd, data: e.data});
         end
         if (fire) begin
            e.op1   = prog_val[in_rs1];
            e.op2   = prog_val[in_rs2];
            e.rd    = in_rd;
            e.rd_we = in_rd_we;
            e.tag   = in_tag;
            e.data  = {4'($urandom_range(0, 15)), 32'($urandom)};
            if (in_rd_we && in_rd != '0) prog_val[in_rd] = e.data;
            expq.push_back(e);
            pres = 1'b0;
            n_acc++;
            seq++;
         end
         tick();
      end

      // drain outstanding work within a bounded window
      in_valid = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 100 && (expq.size() != 0 || wbq.size() != 0); c++) begin
         wb_pop = 1'b0; wb_en = 1'b0;
         if (wbq.size() > 0) begin
            wb_en = 1'b1; wb_addr = wbq[0].rd; wb_data = wbq[0].data; wb_pop = 1'b1;
         end
         #1;
         if (expq.size() != 0) begin
            check("drain_valid", 64'(out_valid), 64'd1);
            check("drain_op1", 64'(out_op1), 64'(expq[0].op1));
            check("drain_op2", 64'(out_op2), 64'(expq[0].op2));
            check("drain_tag", 64'(out_tag), 64'(expq[0].tag));
            if (wb_pop) void'(wbq.pop_front());
            e = expq.pop_front();
            if (e.rd_we && e.rd != '0) wbq.push_back('{rd: e.rd, data: e.data});
         end else if (wb_pop) begin
            void'(wbq.pop_front());
         end
         tick();
      end
      wb_en = 1'b0;
      check("drain_exp_empty", 64'(expq.size()), 64'd0);
      check("drain_wb_empty",  64'(wbq.size()),  64'd0);
      check("rnd_progress", 64'(n_acc > 400), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
